// File: rtl/cdb_pkg.sv
// Shared constants and types for the Common Data Bus arbiter and its users.
package cdb_pkg;

  localparam int N_REQ = 4;

  localparam int REQ_ALU0   = 0;
  localparam int REQ_ALU1   = 1;
  localparam int REQ_MULDIV = 2;
  localparam int REQ_LSU    = 3;

  // Tag 0 means "value ready" in the reservation stations, so it is never broadcast.
  localparam int TAG_NONE = 0;

  localparam int CDB_BW_TAG  = 4;
  localparam int CDB_BW_DATA = 32;

  typedef struct packed {
    logic                   valid;
    logic                   spec;
    logic [CDB_BW_TAG-1:0]  tag;
    logic [CDB_BW_DATA-1:0] wdata;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake, branch resolution and CDB broadcast bundle.
interface cdb_arbiter_if #(
  parameter int N_REQ             = 4,
  parameter int BW_TAG            = 4,
  parameter int BW_PROCESSOR_DATA = 32
);

  logic [N_REQ-1:0]                   i_fu_valid;
  logic [N_REQ-1:0]                   o_fu_ready;
  logic [N_REQ*BW_TAG-1:0]            i_fu_tag_flatten;
  logic [N_REQ*BW_PROCESSOR_DATA-1:0] i_fu_wdata_flatten;
  logic [N_REQ-1:0]                   i_fu_speculation;
  logic                               i_branch_valid;
  logic                               i_branch_correct_prediction;
  logic                               o_cdb_valid;
  logic [BW_TAG-1:0]                  o_cdb_tag;
  logic [BW_PROCESSOR_DATA-1:0]       o_cdb_wdata;
  logic                               o_busy;

  // Functional units, branch unit and CDB consumers.
  modport master (
    output i_fu_valid, i_fu_tag_flatten, i_fu_wdata_flatten, i_fu_speculation,
    output i_branch_valid, i_branch_correct_prediction,
    input  o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata, o_busy
  );

  modport slave (
    input  i_fu_valid, i_fu_tag_flatten, i_fu_wdata_flatten, i_fu_speculation,
    input  i_branch_valid, i_branch_correct_prediction,
    output o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata, o_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr, pointer moves past the winner.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [PW-1:0]    grant_idx
);

  logic [PW-1:0] rr_ptr;

  always_comb begin
    logic [PW:0] cand;
    cand        = '0;
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!grant_valid && req[cand[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
    grant[grant_idx] = grant_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per functional unit, round-robin grant,
// registered broadcast, speculative entries dropped on mispredict.
module cdb_arbiter #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 4,
  parameter int N_REQ             = cdb_pkg::N_REQ
) (
  input logic          clk,
  input logic          rst_n,
  cdb_arbiter_if.slave bus
);
  import cdb_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]             hold_valid;
  logic [N_REQ-1:0]             hold_spec;
  logic [BW_TAG-1:0]            hold_tag   [N_REQ];
  logic [BW_PROCESSOR_DATA-1:0] hold_wdata [N_REQ];

  logic                         flush;
  logic                         commit;
  logic [N_REQ-1:0]             flushed;
  logic [N_REQ-1:0]             eligible;
  logic [N_REQ-1:0]             fu_ready;
  logic [N_REQ-1:0]             accept;
  logic [N_REQ-1:0]             grant;
  logic                         grant_valid;
  logic [PW-1:0]                grant_idx;

  logic                         cdb_valid_q;
  logic [BW_TAG-1:0]            cdb_tag_q;
  logic [BW_PROCESSOR_DATA-1:0] cdb_wdata_q;

  assign flush  = bus.i_branch_valid & ~bus.i_branch_correct_prediction;
  assign commit = bus.i_branch_valid &  bus.i_branch_correct_prediction;

  // Grant depends only on registered state, never on the incoming fu handshake.
  assign flushed  = {N_REQ{flush}} & hold_spec & hold_valid;
  assign eligible = hold_valid & ~flushed;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (eligible),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign fu_ready       = ~hold_valid | grant | flushed;
  assign accept         = bus.i_fu_valid & fu_ready;
  assign bus.o_fu_ready = fu_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      hold_spec  <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        hold_tag[i]   <= '0;
        hold_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          // Tag 0 and squashed speculative results are consumed but never stored.
          hold_valid[i] <= (bus.i_fu_tag_flatten[i*BW_TAG +: BW_TAG] != BW_TAG'(TAG_NONE))
                           && !(flush && bus.i_fu_speculation[i]);
          hold_spec[i]  <= bus.i_fu_speculation[i] && !commit;
          hold_tag[i]   <= bus.i_fu_tag_flatten[i*BW_TAG +: BW_TAG];
          hold_wdata[i] <= bus.i_fu_wdata_flatten[i*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
        end else if (grant[i] || flushed[i]) begin
          hold_valid[i] <= 1'b0;
          hold_spec[i]  <= 1'b0;
        end else if (commit) begin
          hold_spec[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_wdata_q <= '0;
    end else begin
      cdb_valid_q <= grant_valid;
      if (grant_valid) begin
        cdb_tag_q   <= hold_tag[grant_idx];
        cdb_wdata_q <= hold_wdata[grant_idx];
      end
    end
  end

  assign bus.o_cdb_valid = cdb_valid_q;
  assign bus.o_cdb_tag   = cdb_tag_q;
  assign bus.o_cdb_wdata = cdb_wdata_q;
  assign bus.o_busy      = (|hold_valid) | cdb_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic against a reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = 4;
  localparam int BT = 4;
  localparam int BD = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N), .BW_TAG(BT), .BW_PROCESSOR_DATA(BD)) bus ();

  cdb_arbiter #(.BW_PROCESSOR_DATA(BD), .BW_TAG(BT), .N_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         stamp;
    cdb_entry_t e;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         seen[16];

  cdb_entry_t m_hold[N];
  int         m_ptr;
  bit         m_cdb_valid;
  cdb_entry_t p_in[N];
  bit         br_valid, br_correct;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < N; u++) begin
      m_hold[u] = '0;
      p_in[u]   = '0;
    end
    m_ptr       = 0;
    m_cdb_valid = 0;
    br_valid    = 0;
    br_correct  = 0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    bus.i_fu_valid                  = '0;
    bus.i_fu_tag_flatten            = '0;
    bus.i_fu_wdata_flatten          = '0;
    bus.i_fu_speculation            = '0;
    bus.i_branch_valid              = 1'b0;
    bus.i_branch_correct_prediction = 1'b0;
  endtask

  function automatic bit model_busy();
    bit b = m_cdb_valid;
    for (int u = 0; u < N; u++) b |= m_hold[u].valid;
    return b;
  endfunction

  // One clock cycle: drive pending results, check handshake, advance the model.
  task automatic step();
    bit               flush, commit;
    int               g;
    logic [N-1:0]     rdy;
    exp_t             x;
    @(negedge clk);
    for (int u = 0; u < N; u++) begin
      bus.i_fu_valid[u]                  = p_in[u].valid;
      bus.i_fu_speculation[u]            = p_in[u].spec;
      bus.i_fu_tag_flatten[u*BT +: BT]   = p_in[u].tag;
      bus.i_fu_wdata_flatten[u*BD +: BD] = p_in[u].wdata;
    end
    bus.i_branch_valid              = br_valid;
    bus.i_branch_correct_prediction = br_correct;
    #1;
    flush  = br_valid && !br_correct;
    commit = br_valid && br_correct;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int u = (m_ptr + k) % N;
      if (g < 0 && m_hold[u].valid && !(flush && m_hold[u].spec)) g = u;
    end
    for (int u = 0; u < N; u++)
      rdy[u] = !m_hold[u].valid || (g == u) || (flush && m_hold[u].spec);
    chk("fu_ready", bus.o_fu_ready, rdy);
    chk("busy", bus.o_busy, model_busy());
    if (exp_q.size() > 0) chk("missed_broadcast", exp_q[0].stamp > cyc, 1);
    if (g >= 0) begin
      x.stamp = cyc + 1;
      x.e     = m_hold[g];
      exp_q.push_back(x);
      m_ptr = (g + 1) % N;
    end
    m_cdb_valid = (g >= 0);
    for (int u = 0; u < N; u++) begin
      if (p_in[u].valid && rdy[u]) begin
        m_hold[u].valid = (p_in[u].tag != 0) && !(flush && p_in[u].spec);
        m_hold[u].spec  = p_in[u].spec && !commit;
        m_hold[u].tag   = p_in[u].tag;
        m_hold[u].wdata = p_in[u].wdata;
        p_in[u].valid   = 1'b0;
      end else if (g == u || (flush && m_hold[u].spec)) begin
        m_hold[u].valid = 1'b0;
        m_hold[u].spec  = 1'b0;
      end else if (commit) begin
        m_hold[u].spec = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    int i;
    bit pend;
    br_valid = 0;
    i = 0;
    do begin
      step();
      pend = model_busy();
      for (int u = 0; u < N; u++) pend |= p_in[u].valid;
      i++;
    end while (pend && i < 40);
    step();
    chk("drain_done", pend, 0);
  endtask

  task automatic load(input int u, input bit spec, input int tag, input logic [BD-1:0] d);
    p_in[u].valid = 1'b1;
    p_in[u].spec  = spec;
    p_in[u].tag   = BT'(tag);
    p_in[u].wdata = d;
  endtask

  task automatic gen_random();
    for (int u = 0; u < N; u++) begin
      if (!p_in[u].valid && $urandom_range(9) < 7)
        load(u, $urandom_range(3) == 0,
             ($urandom_range(7) == 0) ? 0 : int'($urandom_range(15, 1)), $urandom);
    end
    br_valid   = ($urandom_range(5) == 0);
    br_correct = ($urandom_range(1) == 1);
  endtask

  // Monitor: every broadcast must match the oldest expected entry, in the predicted cycle.
  always @(negedge clk) begin
    if (rst_n && bus.o_cdb_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_broadcast at t=%0t: tag 0x%0h with nothing expected", $time, bus.o_cdb_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.stamp != cyc || bus.o_cdb_tag != e.e.tag || bus.o_cdb_wdata != e.e.wdata) begin
          n_fail++;
          $display("FAIL broadcast at t=%0t: got cyc %0d tag 0x%0h data 0x%0h expected cyc %0d tag 0x%0h data 0x%0h",
                   $time, cyc, bus.o_cdb_tag, bus.o_cdb_wdata, e.stamp, e.e.tag, e.e.wdata);
        end
      end
      chk("tag_none_broadcast", bus.o_cdb_tag == BT'(TAG_NONE), 0);
      seen[bus.o_cdb_tag]++;
    end
  end

  initial begin
    int s5, s6, s7;
    for (int t = 0; t < 16; t++) seen[t] = 0;
    drive_idle();
    model_reset();
    #3;
    chk("rst_cdb_valid", bus.o_cdb_valid, 0);
    chk("rst_cdb_tag", bus.o_cdb_tag, 0);
    chk("rst_cdb_wdata", bus.o_cdb_wdata, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_fu_ready", bus.o_fu_ready, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: two-cycle latency, then busy drops.
    load(REQ_ALU0, 0, 3, 32'h1234);
    step();
    step();
    #1;
    chk("single_valid", bus.o_cdb_valid, 1);
    chk("single_tag", bus.o_cdb_tag, 3);
    chk("single_wdata", bus.o_cdb_wdata, 32'h1234);
    drain();

    // Round robin with every unit continuously requesting.
    for (int c = 0; c < 16; c++) begin
      for (int u = 0; u < N; u++)
        if (!p_in[u].valid) load(u, 0, u + 1, $urandom);
      step();
    end
    drain();

    // Mispredict squashes the speculative entry only.
    s5 = seen[5]; s6 = seen[6];
    load(REQ_MULDIV, 1, 5, 32'h5555);
    load(REQ_LSU, 0, 6, 32'h6666);
    step();
    br_valid = 1; br_correct = 0;
    step();
    drain();
    chk("flush_tag5_count", seen[5] - s5, 0);
    chk("flush_tag6_count", seen[6] - s6, 1);

    // Commit clears speculation so a later flush does not squash it.
    s7 = seen[7];
    load(REQ_ALU0, 0, 8, 32'h8);
    load(REQ_ALU1, 0, 9, 32'h9);
    load(REQ_MULDIV, 1, 7, 32'h7777);
    load(REQ_LSU, 0, 10, 32'hA);
    step();
    br_valid = 1; br_correct = 1;
    step();
    br_valid = 1; br_correct = 0;
    step();
    drain();
    chk("commit_tag7_count", seen[7] - s7, 1);

    // Tag 0 accepted but never broadcast; then back-to-back on one unit.
    load(REQ_ALU1, 0, 0, 32'hDEAD);
    step();
    drain();
    chk("tag0_count", seen[0], 0);
    for (int c = 0; c < 6; c++) begin
      load(REQ_ALU0, 0, 11 + (c % 4), $urandom);
      step();
    end
    drain();

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      gen_random();
      step();
    end
    drain();

    // Reset with buffers full: outputs clear at once, nothing broadcast after.
    for (int u = 0; u < N; u++) load(u, 0, u + 1, $urandom);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cdb_valid", bus.o_cdb_valid, 0);
    chk("midrst_cdb_tag", bus.o_cdb_tag, 0);
    chk("midrst_cdb_wdata", bus.o_cdb_wdata, 0);
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_fu_ready", bus.o_fu_ready, 4'hF);
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
